work_dispatcher: RTL and testbench

WORK_DISPATCHER -- requirements
Module: work_dispatcher

---
 rtl/work_dispatcher.sv | 160 ++++++++++++++++
 tb/tb_work_dispatcher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/work_dispatcher.sv
// work_dispatcher: accepts a mining job from the host and streams its midstate
// and tail bytes serially to the miner. It then waits in MINING for a solution
// claim and hands the claimed nonce back to the host. A new job accepted in
// MINING preempts the current one.
// Optional feature: define DISPATCH_TIMEOUT_EN to give up on a job after
// TIMEOUT_CYCLES cycles spent in MINING.
module work_dispatcher #(
  parameter int MID_BYTES      = 32,
  parameter int TAIL_BYTES     = 12,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [8*MID_BYTES-1:0]  job_midstate,
  input  logic [8*TAIL_BYTES-1:0] job_tail,
  output logic                    start_found,
  output logic                    shift_en,
  output logic [7:0]              shift_data,
  output logic                    midstate_shifts_done,
  output logic                    remaining_shifts_done,
  input  logic                    sol_claim,
  input  logic [31:0]             sol_nonce,
  output logic                    sol_response,
  output logic                    nonce_valid,
  output logic [31:0]             nonce,
  input  logic                    nonce_ack,
  input  logic                    nonce_accept,
  output logic                    busy
);
  localparam int MAXB = (MID_BYTES > TAIL_BYTES) ? MID_BYTES : TAIL_BYTES;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    IDLE, START, SEND_MID, SEND_TAIL, MINING, REPORT
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [8*MID_BYTES-1:0]  mid_q;
  logic [8*TAIL_BYTES-1:0] tail_q;
  logic [31:0]             nonce_q;
  logic                    sol_resp_q, sol_resp_d;
  logic                    accept, mid_shift, tail_shift, mid_last, tail_last;
  logic                    tmo_hit;

  assign accept     = job_valid && job_ready;
  // The cycle after the last byte of a phase carries its done pulse.
  assign mid_last   = (cnt_q == CW'(MID_BYTES));
  assign tail_last  = (cnt_q == CW'(TAIL_BYTES));
  assign mid_shift  = (state_q == SEND_MID)  && !mid_last;
  assign tail_shift = (state_q == SEND_TAIL) && !tail_last;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == MINING) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Mining-cycle counter: zeroed while loading, runs in MINING, holds in REPORT.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SEND_TAIL)   tmo_d = '0;
    else if (state_q == MINING) tmo_d = tmo_q + TW'(1);
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; also decides when the one-cycle sol_response is due.
  always_comb begin
    state_d    = state_q;
    sol_resp_d = 1'b0;
    unique case (state_q)
      IDLE:      if (accept) state_d = START;
      START:     state_d = SEND_MID;
      SEND_MID:  if (mid_last) state_d = SEND_TAIL;
      SEND_TAIL: if (tail_last) state_d = MINING;
      MINING: begin
        // A new job beats a claim arriving in the same cycle.
        if (accept)         state_d = START;
        else if (sol_claim) state_d = REPORT;
        else if (tmo_hit) begin
          state_d    = IDLE;
          sol_resp_d = 1'b1;
        end
      end
      REPORT: begin
        if (nonce_ack) begin
          if (nonce_accept) begin
            state_d    = IDLE;
            sol_resp_d = 1'b1;
          end else begin
            state_d = MINING;
          end
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Output decode from the current state and byte counter.
  always_comb begin
    job_ready             = (state_q == IDLE) || (state_q == MINING);
    start_found           = (state_q == START);
    shift_en              = mid_shift || tail_shift;
    shift_data            = 8'h00;
    if (mid_shift)  shift_data = mid_q[8*MID_BYTES-1 -: 8];
    if (tail_shift) shift_data = tail_q[8*TAIL_BYTES-1 -: 8];
    midstate_shifts_done  = (state_q == SEND_MID)  && mid_last;
    remaining_shifts_done = (state_q == SEND_TAIL) && tail_last;
    nonce_valid           = (state_q == REPORT);
    nonce                 = nonce_q;
    sol_response          = sol_resp_q;
    busy                  = (state_q != IDLE);
  end

  // Byte counter restarts from zero whenever a send phase is entered.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == SEND_MID) || (state_q == SEND_TAIL)))
      cnt_d = cnt_q + CW'(1);
  end

  // Job shift registers, nonce latch, byte counter and response pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mid_q      <= '0;
      tail_q     <= '0;
      nonce_q    <= '0;
      cnt_q      <= '0;
      sol_resp_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sol_resp_q <= sol_resp_d;
      if (accept) begin
        mid_q  <= job_midstate;
        tail_q <= job_tail;
      end else begin
        if (mid_shift)  mid_q  <= mid_q << 8;
        if (tail_shift) tail_q <= tail_q << 8;
      end
      if ((state_q == MINING) && !accept && sol_claim)
        nonce_q <= sol_nonce;
    end
  end
endmodule

// File: tb/tb_work_dispatcher.sv
// Bench for work_dispatcher: directed scenarios with randomized job data,
// nonces and delays; expectations come from a cycle-offset model of a job load.
module tb_work_dispatcher;
  localparam int MB = 32;
  localparam int TB = 12;
  localparam int LOAD = MB + TB + 4;   // cycle offset of MINING after accept

  logic          clk = 1'b0;
  logic          n_rst;
  logic          job_valid, job_ready;
  logic [8*MB-1:0] job_midstate;
  logic [8*TB-1:0] job_tail;
  logic          start_found, shift_en, midstate_shifts_done, remaining_shifts_done;
  logic [7:0]    shift_data;
  logic          sol_claim, sol_response, nonce_valid, nonce_ack, nonce_accept, busy;
  logic [31:0]   sol_nonce, nonce;

  int checks = 0;
  int errors = 0;

  work_dispatcher #(
    .MID_BYTES(MB), .TAIL_BYTES(TB)
`ifdef DISPATCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_tail(job_tail),
    .start_found(start_found), .shift_en(shift_en), .shift_data(shift_data),
    .midstate_shifts_done(midstate_shifts_done),
    .remaining_shifts_done(remaining_shifts_done),
    .sol_claim(sol_claim), .sol_nonce(sol_nonce), .sol_response(sol_response),
    .nonce_valid(nonce_valid), .nonce(nonce),
    .nonce_ack(nonce_ack), .nonce_accept(nonce_accept), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs all control outputs so one comparison covers a whole cycle.
  function automatic logic [15:0] pack(input logic sf, se, input logic [7:0] d,
                                       input logic md, rd, sr, nv, jr, bz);
    return {sf, se, d, md, rd, sr, nv, jr, bz};
  endfunction

  function automatic logic [15:0] obs_vec();
    return pack(start_found, shift_en, shift_data, midstate_shifts_done,
                remaining_shifts_done, sol_response, nonce_valid, job_ready, busy);
  endfunction

  task automatic clear_inputs();
    job_valid = 0; sol_claim = 0; nonce_ack = 0; nonce_accept = 0;
    job_midstate = '0; job_tail = '0; sol_nonce = '0;
  endtask

  // Offer a job at the current negedge (IDLE or MINING) and check every cycle
  // of the load up to offset stop_k. Ignored inputs are driven with junk.
  task automatic job_load(input logic [8*MB-1:0] mid, input logic [8*TB-1:0] tail,
                          input bit with_claim, input int stop_k);
    logic [15:0] e;
    logic [7:0]  b;
    job_valid = 1; job_midstate = mid; job_tail = tail;
    sol_claim = with_claim; sol_nonce = $urandom;
    chk("accept_ready", job_ready, 1);
    for (int k = 1; k <= stop_k; k++) begin
      @(negedge clk);
      if (k < LOAD) begin
        job_valid = 1'($urandom_range(0, 1)); sol_claim = 1'($urandom_range(0, 1));
        nonce_ack = 1'($urandom_range(0, 1)); nonce_accept = 1'($urandom_range(0, 1));
        job_midstate = {8{$urandom}}; job_tail = {3{$urandom}}; sol_nonce = $urandom;
      end else clear_inputs();
      if (k == 1)                     e = pack(1, 0, 0, 0, 0, 0, 0, 0, 1);
      else if (k <= MB + 1) begin
        b = mid[8*(MB-1-(k-2)) +: 8];   e = pack(0, 1, b, 0, 0, 0, 0, 0, 1);
      end
      else if (k == MB + 2)           e = pack(0, 0, 0, 1, 0, 0, 0, 0, 1);
      else if (k <= MB + TB + 2) begin
        b = tail[8*(TB-1-(k-MB-3)) +: 8]; e = pack(0, 1, b, 0, 0, 0, 0, 0, 1);
      end
      else if (k == MB + TB + 3)      e = pack(0, 0, 0, 0, 1, 0, 0, 0, 1);
      else                            e = pack(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk($sformatf("load_k%0d", k), 64'(obs_vec()), 64'(e));
    end
    clear_inputs();
  endtask

  task automatic mine(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("mining", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 1, 1)));
    end
  endtask

  // Raise a claim in MINING, hold in REPORT with junk inputs, then answer it.
  task automatic claim_ack(input logic [31:0] v, input bit acc);
    int h;
    sol_claim = 1; sol_nonce = v;
    @(negedge clk);
    clear_inputs();
    chk("report", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 1, 0, 1)));
    chk("report_nonce", 64'(nonce), 64'(v));
    h = $urandom_range(0, 4);
    for (int i = 0; i < h; i++) begin
      sol_claim = 1; sol_nonce = $urandom; job_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      clear_inputs();
      chk("report_hold", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 1, 0, 1)));
      chk("report_hold_nonce", 64'(nonce), 64'(v));
    end
    nonce_ack = 1; nonce_accept = acc;
    @(negedge clk);
    clear_inputs();
    if (acc) begin
      chk("sol_resp", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 1, 0, 1, 0)));
      @(negedge clk);
      chk("idle_after_resp", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    end else begin
      chk("reject_mining", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 1, 1)));
    end
  endtask

  function automatic logic [8*MB-1:0] rnd_mid();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [8*MB-1:0] m;
    logic [8*TB-1:0] t;
    clear_inputs();
    n_rst = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    chk("reset_nonce", 64'(nonce), 64'h0);
    n_rst = 1;
    @(negedge clk);

    // Byte-pattern job: midstate 00..1F, tail A0..AB, most-significant first.
    for (int i = 0; i < MB; i++) m[8*(MB-1-i) +: 8] = 8'(i);
    for (int i = 0; i < TB; i++) t[8*(TB-1-i) +: 8] = 8'(8'hA0 + i);
    job_load(m, t, 0, LOAD);
    mine($urandom_range(0, 3));
    claim_ack(32'hDEADBEEF, 1);

    // Reject path, then a second claim that is accepted.
    job_load(rnd_mid(), {$urandom, $urandom, $urandom}, 0, LOAD);
    mine($urandom_range(0, 2));
    claim_ack($urandom, 0);
    mine($urandom_range(0, 2));
    claim_ack(32'h12345678, 1);

    // Preemption: job offer and claim together in MINING; job wins.
    job_load(rnd_mid(), {$urandom, $urandom, $urandom}, 0, LOAD);
    mine(1);
    job_load(rnd_mid(), {$urandom, $urandom, $urandom}, 1, LOAD);
    claim_ack($urandom, 1);

    // Reset while midstate byte 10 is on the wire, then a clean reload.
    job_load(rnd_mid(), {$urandom, $urandom, $urandom}, 0, 12);
    n_rst = 0;
    #1;
    chk("midload_reset_outs", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    chk("midload_reset_nonce", 64'(nonce), 64'h0);
    @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    job_load(rnd_mid(), {$urandom, $urandom, $urandom}, 0, LOAD);

    // Current job is in MINING with no claim.
`ifdef DISPATCH_TIMEOUT_EN
    mine(15);
    @(negedge clk);
    chk("timeout_resp", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 1, 0, 1, 0)));
    @(negedge clk);
    chk("timeout_idle", 64'(obs_vec()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 1, 0)));
`else
    mine(40);
    claim_ack($urandom, 1);
`endif

    // Randomized jobs with random reject counts.
    for (int r = 0; r < 4; r++) begin
      job_load(rnd_mid(), {$urandom, $urandom, $urandom}, 0, LOAD);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        mine($urandom_range(0, 2));
        claim_ack($urandom, 0);
      end
      mine($urandom_range(0, 2));
      claim_ack($urandom, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
